ring_osc_meter: RTL and testbench
=================================

# ring_osc_meter

Single-clock measurement controller for the on-chip ring oscillator. It enables the ring, waits for it to settle, then counts synchronized rising edges of the ring output (or of a divided copy of it) over a programmable gate of clock cycles. At the end it disables the ring, reports the edge count with a saturation flag, and pulses `done`. It sits between the ring oscillator's `nrst`/`osc` pins and the design's readout logic.

## Interface
- `CNT_W`, default 16: width of the edge counter and of `count`.
- `GATE_W`, default 16: width of `gate_cycles`.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `osc_in`; minimum 2.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request a measurement. Sampled only in IDLE.
- `gate_cycles` in GATE_W: gate length in clk cycles. Latched on an accepted `start`.
- `osc_in` in 1: ring output, asynchronous to `clk`. The source must keep it below clk/2 by pre-dividing if necessary.
- `ring_nrst` out 1: drives the ring's `nrst`. A value of 1 lets the ring oscillate.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the result is valid.
- `count` out CNT_W: result of the last measurement. Held until the next accepted `start`.
- `overflow` out 1: high if the counter saturated during the last measurement. Held like `count`.

## Operation
- States: IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - Outputs: `ring_nrst`=0, `busy`=0.
  - On `start`=1: latch `gate_cycles`, clear `count` and `overflow`, load the settle counter, go to SETTLE.
- SETTLE:
  - Outputs: `ring_nrst`=1, `busy`=1.
  - Stays for SETTLE_CYC=4 cycles. This flushes the synchronizer and lets the ring start. Edges seen here are not counted.
  - Then go to MEASURE, or directly to DONE if the latched gate is 0.
- MEASURE:
  - Outputs: `ring_nrst`=1, `busy`=1.
  - Lasts exactly the latched gate count of cycles.
  - Each cycle with a detected rising edge increments `count`. An edge is detected when the last synchronizer stage is 1 and the previous sample was 0.
  - When `count` is all-ones and another edge arrives, `count` holds and `overflow` sets; `overflow` is sticky until the next accepted start.
  - After the last gate cycle, go to DONE.
- DONE:
  - Outputs: `ring_nrst`=0, `busy`=0, `done`=1 for this single cycle.
  - Then go to IDLE. `start` in the DONE cycle is ignored.
- `start` while `busy` is ignored. `gate_cycles` changes after latching have no effect.
- The edge-detect history register is cleared on entry to SETTLE, so a stale level from a previous run never produces a spurious edge.
- All arithmetic is unsigned. The gate down-counter is GATE_W bits; the edge counter is CNT_W bits with saturation and never wraps.

## Timing
- Reset values: state IDLE, `ring_nrst`=0, `busy`=0, `done`=0, `count`=0, `overflow`=0, synchronizer and edge history 0.
- Reset asserted mid-operation aborts immediately to the reset values; no `done` is issued.
- `start` accepted at rising edge k, with gate G:
  - `busy` is 1 in cycles k+1 to k+4+G.
  - SETTLE occupies k+1 to k+4.
  - MEASURE occupies k+5 to k+4+G.
  - `done`=1 in cycle k+5+G, with `count`/`overflow` final in that same cycle.
- With G=0, `done` is in cycle k+5.
- Edge latency from `osc_in` to the count is SYNC_STAGES+1 cycles. An edge arriving late in the gate may be counted in the next run's settle window, which discards it.

## Structure
- Package `ring_meter_pkg`:
  - state enum `meter_state_t` (IDLE, SETTLE, MEASURE, DONE);
  - localparam `SETTLE_CYC`=4;
  - settle counter width 3.
- Sub-module `sync_rise_detect`:
  - parameter SYNC_STAGES;
  - ports `clk`, `rst`, `clr`, `d_async`, `rise`;
  - a flop chain plus a one-flop history.
- The top module holds the FSM, gate down-counter and saturating edge counter.

## Test plan
- `osc_in` rising every 4 clk, G=100 → `done` in cycle k+105, `count`=25 (±1 for phase), `overflow`=0, `ring_nrst` high exactly k+1 to k+104.
- `osc_in` stuck at 0, G=50 → `count`=0, `done` once, `busy` falling with `done`.
- CNT_W=4, `osc_in` period 4 clk, G=100 → `count`=15, `overflow`=1.
- G=0 → `done` in cycle k+5, `count`=0, edges during SETTLE not counted.
- Pulse `start` again during MEASURE and with a changed `gate_cycles` → ignored. The result matches the original G, and only one `done` is issued.
- Assert `rst` in the middle of MEASURE → all outputs return to reset values asynchronously. No `done` is issued. A new `start` after release measures normally.

Source files
------------

// File: rtl/ring_meter_pkg.sv
// ============================================================================
// Module   : ring_meter_pkg
// Purpose  : Shared types and constants for the ring oscillator meter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ring_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } meter_state_t;

  localparam int SETTLE_CYC = 4;
  localparam int SETTLE_W   = 3;

endpackage

`default_nettype wire

// File: rtl/sync_rise_detect.sv
// ============================================================================
// Module   : sync_rise_detect
// Purpose  : Synchronizes an asynchronous level and flags its rising edges.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      // Clearing history forgets any level left over from the previous run.
      hist_q <= clr ? 1'b0 : sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

`default_nettype wire

// File: rtl/ring_osc_meter.sv
// ============================================================================
// Module   : ring_osc_meter
// Purpose  : Gated edge counter for the on-chip ring oscillator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ring_osc_meter
  import ring_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              osc_in,
  output logic              ring_nrst,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  meter_state_t        state_q,  state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [GATE_W-1:0]   gate_q,   gate_d;
  logic [CNT_W-1:0]    count_q,  count_d;
  logic                ovf_q,    ovf_d;
  logic                accept;
  logic                rise;

  assign accept = (state_q == ST_IDLE) && start;

  sync_rise_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .d_async(osc_in),
    .rise   (rise)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    gate_d   = gate_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          gate_d   = gate_cycles;
          count_d  = '0;
          ovf_d    = 1'b0;
          settle_d = SETTLE_W'(SETTLE_CYC - 1);
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = (gate_q == '0) ? ST_DONE : ST_MEASURE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_MEASURE: begin
        gate_d = gate_q - 1'b1;
        if (gate_q == GATE_W'(1)) begin
          state_d = ST_DONE;
        end
        // Saturate rather than wrap so a too-fast ring is reported, not aliased.
        if (rise) begin
          if (&count_q) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      gate_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      gate_q   <= gate_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
  assign ring_nrst = busy;
  assign done      = (state_q == ST_DONE);
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ring_osc_meter.sv
// ============================================================================
// Module   : tb_ring_osc_meter
// Purpose  : Randomized self-checking bench for ring_osc_meter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ring_osc_meter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] gate_cycles;
  logic        osc_in = 1'b0;

  logic        nrst_a, busy_a, done_a, ovf_a;
  logic [15:0] count_a;
  logic        nrst_b, busy_b, done_b, ovf_b;
  logic [3:0]  count_b;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  int osc_mode = 0;
  int osc_per  = 4;
  int osc_ph   = 0;
  logic osc_nxt;
  int rises[$];

  ring_osc_meter #(.CNT_W(16), .GATE_W(16), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles), .osc_in(osc_in),
    .ring_nrst(nrst_a), .busy(busy_a), .done(done_a), .count(count_a), .overflow(ovf_a)
  );

  ring_osc_meter #(.CNT_W(4), .GATE_W(16), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles), .osc_in(osc_in),
    .ring_nrst(nrst_b), .busy(busy_b), .done(done_b), .count(count_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  // Cycle n is the period that ends at the n-th counted rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Ring model: changes on the falling edge and logs the cycle of each rise.
  always @(negedge clk) begin
    if (osc_mode == 0) begin
      osc_nxt = 1'b0;
    end else begin
      osc_nxt = (osc_ph % osc_per) < (osc_per / 2);
      osc_ph  = osc_ph + 1;
    end
    if (osc_nxt && !osc_in) rises.push_back(cyc);
    osc_in = osc_nxt;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Rises whose synchronized edge lands inside the measurement window.
  function automatic int model_edges(input int k, input int g, input int s);
    int n = 0;
    foreach (rises[i])
      if (rises[i] + s >= k + 5 && rises[i] + s <= k + 4 + g) n++;
    return n;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_busy_a"}, busy_a, 0);
    check_val({tag, "_nrst_a"}, nrst_a, 0);
    check_val({tag, "_done_a"}, done_a, 0);
    check_val({tag, "_cnt_a"},  count_a, 0);
    check_val({tag, "_ovf_a"},  ovf_a, 0);
    check_val({tag, "_busy_b"}, busy_b, 0);
    check_val({tag, "_cnt_b"},  count_b, 0);
    check_val({tag, "_ovf_b"},  ovf_b, 0);
  endtask

  task automatic run_meas(input int g, input int mode, input int per,
                          input bit repulse, input bit do_rst);
    int  k, n2, n3, exp_a, exp_b, exp_ob;
    logic exp_busy, exp_done;
    @(negedge clk);
    osc_mode    = mode;
    osc_per     = per;
    gate_cycles = 16'(g);
    start       = 1'b1;
    k           = cyc;
    exp_a = 0; exp_b = 0; exp_ob = 0;
    @(negedge clk);
    for (int j = k + 1; j <= k + 6 + g; j++) begin
      exp_busy = (j <= k + 4 + g);
      exp_done = (j == k + 5 + g);
      check_val("busy_a", busy_a, 32'(exp_busy));
      check_val("nrst_a", nrst_a, 32'(exp_busy));
      check_val("done_a", done_a, 32'(exp_done));
      check_val("busy_b", busy_b, 32'(exp_busy));
      check_val("done_b", done_b, 32'(exp_done));
      if (exp_done) begin
        n2     = model_edges(k, g, 2);
        n3     = model_edges(k, g, 3);
        exp_a  = n2;
        exp_b  = (n3 > 15) ? 15 : n3;
        exp_ob = (n3 > 15) ? 1 : 0;
        check_val("count_a", count_a, 32'(exp_a));
        check_val("ovf_a",   ovf_a,   0);
        check_val("count_b", count_b, 32'(exp_b));
        check_val("ovf_b",   ovf_b,   32'(exp_ob));
      end
      if (do_rst && j == k + 5 + g / 2) begin
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        check_val("rst_done_a", done_a, 0);
        rst   = 1'b0;
        start = 1'b0;
        return;
      end
      // Extra start pulses: once mid-measure, once in the DONE cycle.
      start       = (repulse && j == k + 6) || exp_done;
      gate_cycles = 16'($urandom);
      @(negedge clk);
    end
    check_val("idle_busy_a", busy_a, 0);
    check_val("held_cnt_a",  count_a, 32'(exp_a));
    check_val("held_cnt_b",  count_b, 32'(exp_b));
    check_val("held_ovf_b",  ovf_b,   32'(exp_ob));
  endtask

  initial begin
    int g, mode, per;
    bit rp, rs;
    rst         = 1'b1;
    start       = 1'b0;
    gate_cycles = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_meas(100, 1, 4, 1'b0, 1'b0);
    run_meas(50,  0, 4, 1'b0, 1'b0);
    run_meas(0,   1, 2, 1'b0, 1'b0);
    run_meas(60,  1, 3, 1'b1, 1'b0);
    run_meas(80,  1, 5, 1'b0, 1'b1);
    run_meas(40,  1, 4, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      g      = $urandom_range(0, 120);
      mode   = ($urandom_range(0, 4) != 0) ? 1 : 0;
      per    = $urandom_range(2, 9);
      osc_ph = $urandom_range(0, 15);
      rp     = ($urandom_range(0, 1) == 1) && (g >= 3);
      rs     = ($urandom_range(0, 5) == 0) && (g >= 4);
      run_meas(g, mode, per, rp, rs);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
